trace_capture: RTL
==================

# trace_capture

Parametrised on-chip trace buffer for the CPU that records per-cycle execution state: PC, both register-file read ports, and the N/Z flags. It replaces free-running `$monitor` printing with a triggered, depth-limited capture. It arms on command, keeps a rolling pre-trigger history, and stops after a programmable post-trigger count. The captured entries are then read out oldest-first over a valid/ready port. It sits beside the CPU core and observes `pc`, `read_data1`, `read_data2`, `N` and `Z`.

## Interface
- `PC_W`, default 8: PC width.
- `DATA_W`, default 16: register data width.
- `DEPTH`, default 64: buffer entries. Must be a power of two and at least 4.
- `CW`: derived, equal to $clog2(DEPTH)+1.
- `E`: derived entry width, equal to PC_W+2*DATA_W+2.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `arm` in 1: single-cycle pulse that starts or restarts a capture.
- `mode` in 1: 0 captures every enabled cycle; 1 captures only when the sample differs from the last written entry.
- `en` in 1: sample enable.
- `trig_en` in 1: enables the PC-match trigger.
- `trig_pc` in PC_W: PC value to match.
- `sw_trig` in 1: software trigger.
- `post_count` in CW: number of entries to write after the trigger entry. Latched on `arm`.
- `pc_in` in PC_W: observed PC.
- `rd1_in`, `rd2_in` in DATA_W: observed register read data.
- `n_in`, `z_in` in 1: observed flags.
- `rd_valid` out 1: a readout entry is available.
- `rd_ready` in 1: consumer accepts the readout entry.
- `rd_data` out E: readout entry, packed as {pc, rd1, rd2, n, z}.
- `busy` out 1: state is ARMED or POST.
- `triggered` out 1: the trigger has fired in this capture.
- `overflow` out 1: the pre-trigger history wrapped, so older entries were lost.
- `fill` out CW: number of valid entries.

## Operation
- States are IDLE, ARMED, POST and DONE. Reset enters IDLE and clears every output, pointer and the last-sample register.
- A sample is qualified when all of the following hold:
  - `en` is 1;
  - the state is ARMED or POST;
  - either `mode` is 0, or `mode` is 1 and the sample differs from the last written entry. The first write after `arm` is always taken.
- A qualified sample is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- `fill` saturates at DEPTH. A write while `fill` equals DEPTH sets `overflow`.
- In ARMED, the trigger condition is a qualified sample with either `trig_en` set and `pc_in` equal to `trig_pc`, or `sw_trig` set. That sample is written and `triggered` is set.
  - If the latched `post_count` is 0, the next state is DONE.
  - Otherwise the next state is POST and `post_cnt` is loaded with `post_count`.
- In POST, every qualified write decrements `post_cnt`. The write that takes it from 1 to 0 moves the state to DONE.
- Triggers are ignored in POST and DONE.
- In DONE, the read pointer starts at `wr_ptr - fill` (mod DEPTH). `rd_data` is registered.
- A handshake (`rd_valid` and `rd_ready` both 1) advances the read pointer and decrements `fill`. When `fill` reaches 0, the state returns to IDLE. `triggered` and `overflow` hold until the next `arm`.
- `arm` in any state has priority over everything else in the same cycle. It clears the pointers, `fill`, `triggered` and `overflow`, and enters ARMED.
  - The sample in the `arm` cycle is not captured.
  - An `arm` during DONE aborts the readout.
- A `fill` of 0 in DONE cannot occur, because DONE always follows at least one write.

## Timing
- A qualified sample in cycle t is stored at the edge ending t. `fill` reflects it in t+1.
- `busy` goes to 1 in the cycle after `arm`.
- The transition to DONE happens at the edge of the final write.
- `rd_valid` rises one cycle after entering DONE. It carries the oldest entry.
- While `rd_valid` is 1 and `rd_ready` is 0, `rd_data` is held stable.
- After a handshake, the next entry is presented in the following cycle with no bubble, so full-rate readout is 1 entry/cycle.
- `rd_valid` drops in the cycle after the last handshake.
- An asynchronous assertion of `reset` mid-capture or mid-readout forces IDLE and clears all outputs immediately.

## Test plan
All scenarios use DEPTH=8 and PC_W=8.
- **Basic capture:** `mode`=0, `trig_pc`=5, `trig_en`=1, `post_count`=2. `pc_in` runs 0,1,2,… starting the cycle after `arm`, with `en`=1 → DONE after pc 7 is written, `fill`=8, `overflow`=0. Readout gives pc 0..7 in order, with rd1/rd2/n/z matching the driven values.
- **Wrap:** `trig_pc`=12, `post_count`=1, same stimulus → `overflow`=1, `fill`=8. Readout gives pc 6..13.
- **Change-only:** `mode`=1, pc held at 3 for 4 cycles, then 4, 4, then 5 with `sw_trig`=1 and `post_count`=0 → exactly 3 entries are captured (pc 3, 4, 5). DONE is reached on the pc-5 cycle.
- **Backpressure:** hold `rd_ready`=0 for 3 cycles after `rd_valid` rises → `rd_data` is unchanged throughout. Then `rd_ready`=1 gives 8 consecutive handshakes, `fill` ends at 0 and the state is IDLE.
- **Abort and reset:** `arm` after 3 readout handshakes → `rd_valid`=0 the next cycle, `fill`=0, `busy`=1. Asserting `reset` low during POST → `busy`, `triggered`, `overflow`, `fill` and `rd_valid` are all 0 immediately.
- **Arm/trigger collision:** `arm` and a `trig_pc` match in the same cycle → no entry is written and the state is ARMED. A trigger on a later cycle works normally.

Source files
------------

// File: rtl/trace_capture_if.sv
// Trace observation bus (pc, register read data, flags) plus the valid/ready readout port.
// master: the trace buffer. slave: the core-side observer and the readout consumer.
interface trace_capture_if #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 16
);
    localparam int E = PC_W + 2*DATA_W + 2;

    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] rd1_in;
    logic [DATA_W-1:0] rd2_in;
    logic              n_in;
    logic              z_in;
    logic              rd_valid;
    logic              rd_ready;
    logic [E-1:0]      rd_data;

    modport master (
        input  pc_in, rd1_in, rd2_in, n_in, z_in, rd_ready,
        output rd_valid, rd_data
    );

    modport slave (
        output pc_in, rd1_in, rd2_in, n_in, z_in, rd_ready,
        input  rd_valid, rd_data
    );
endinterface

// File: rtl/trace_capture.sv
// Triggered trace buffer: rolling pre-trigger history, post_count entries after the trigger, oldest-first readout.
// Samples stored at the edge ending their cycle; rd_data is registered, holds under rd_ready=0, streams 1 entry/cycle.
module trace_capture #(
    parameter  int PC_W   = 8,
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 64,
    localparam int CW     = $clog2(DEPTH) + 1,
    localparam int E      = PC_W + 2*DATA_W + 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            arm,
    input  logic            mode,
    input  logic            en,
    input  logic            trig_en,
    input  logic [PC_W-1:0] trig_pc,
    input  logic            sw_trig,
    input  logic [CW-1:0]   post_count,
    trace_capture_if.master tif,
    output logic            busy,
    output logic            triggered,
    output logic            overflow,
    output logic [CW-1:0]   fill
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic              n;
        logic              z;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    state_t        state;
    entry_t        mem [DEPTH];
    entry_t        sample;
    entry_t        last_smp;
    entry_t        rd_data;
    logic          rd_valid;
    logic          have_last;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] post_cnt;
    logic [CW-1:0] post_lat;
    logic          capturing;
    logic          qual;
    logic          trig_hit;
    logic          full;
    logic          hs;

    assign sample    = '{pc: tif.pc_in, rd1: tif.rd1_in, rd2: tif.rd2_in, n: tif.n_in, z: tif.z_in};
    assign capturing = (state == ARMED) || (state == POST);
    // In change-only mode the first write after arm has no reference sample, so it is always taken.
    assign qual      = en && capturing && !arm && (!mode || !have_last || (sample != last_smp));
    assign trig_hit  = (state == ARMED) && qual && ((trig_en && (tif.pc_in == trig_pc)) || sw_trig);
    assign full      = (fill == CW'(DEPTH));
    assign hs        = rd_valid && tif.rd_ready;
    // Oldest unread entry; wr_ptr is frozen in DONE, so this advances as fill drains.
    assign rd_ptr    = wr_ptr - fill[AW-1:0];
    assign rd_nxt    = rd_ptr + AW'(1);

    assign tif.rd_valid = rd_valid;
    assign tif.rd_data  = rd_data;

    always_ff @(posedge clk) begin
        if (qual) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
            fill      <= '0;
            wr_ptr    <= '0;
            post_cnt  <= '0;
            post_lat  <= '0;
            have_last <= 1'b0;
            last_smp  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else if (arm) begin
            state     <= ARMED;
            busy      <= 1'b1;
            triggered <= 1'b0;
            overflow  <= 1'b0;
            fill      <= '0;
            wr_ptr    <= '0;
            post_cnt  <= '0;
            post_lat  <= post_count;
            have_last <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (qual) begin
                wr_ptr    <= wr_ptr + AW'(1);
                last_smp  <= sample;
                have_last <= 1'b1;
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    fill <= fill + CW'(1);
                end
            end

            case (state)
                ARMED: begin
                    if (trig_hit) begin
                        triggered <= 1'b1;
                        if (post_lat == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= POST;
                            post_cnt <= post_lat;
                        end
                    end
                end
                POST: begin
                    if (qual) begin
                        post_cnt <= post_cnt - CW'(1);
                        if (post_cnt == CW'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!rd_valid) begin
                        rd_valid <= 1'b1;
                        rd_data  <= mem[rd_ptr];
                    end else if (hs) begin
                        fill <= fill - CW'(1);
                        if (fill == CW'(1)) begin
                            rd_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            rd_data <= mem[rd_nxt];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
